// File: rtl/mips_debug_sequencer_if.sv
// UART-side handshake bundle for the MIPS debug sequencer.
//   rx_done       : byte-received pulse (1 cycle), qualifies uart_data_in
//   uart_data_in  : received byte
//   tx_done       : byte-sent pulse (1 cycle)
//   tx_start      : transmit request pulse (1 cycle)
//   uart_data_out : byte to transmit, held until tx_done
// Modports: master = sequencer side, slave = UART side.
interface mips_debug_sequencer_if #(
   parameter int LEN_DATA = 8
);
   logic                rx_done;
   logic [LEN_DATA-1:0] uart_data_in;
   logic                tx_done;
   logic                tx_start;
   logic [LEN_DATA-1:0] uart_data_out;

   modport master (
      input  rx_done,
      input  uart_data_in,
      input  tx_done,
      output tx_start,
      output uart_data_out
   );

   modport slave (
      output rx_done,
      output uart_data_in,
      output tx_done,
      input  tx_start,
      input  uart_data_out
   );
endinterface

// File: rtl/mips_debug_sequencer.sv
// Host-side debug controller for the pipelined MIPS core.
// Decodes single-byte UART commands: load a program word by word into instruction
// memory, free-run until halt, or single-step; after a run/step the PC is sent back
// over the UART as 4 bytes, LSB first.
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   uart                  : UART handshake (rx_done/uart_data_in, tx_start/uart_data_out/tx_done)
//   halt, pc              : MIPS halt level and current PC
//   addr_mem_inst         : instruction memory word index
//   ins_to_mem            : instruction word to write
//   write_enable_ram_inst : instruction memory write strobe
//   reset_mips            : one-cycle MIPS reset pulse after a program load
//   ctrl_clk_mips         : MIPS clock enable
//   debug                 : 1 = step mode, 0 = run mode
//   state_out             : one-hot state for LEDs
module mips_debug_sequencer #(
   parameter int                  LEN                = 32,
   parameter int                  LEN_DATA           = 8,
   parameter int                  cant_instrucciones = 64,
   parameter logic [LEN_DATA-1:0] CMD_LOAD           = 8'h4C,
   parameter logic [LEN_DATA-1:0] CMD_RUN            = 8'h52,
   parameter logic [LEN_DATA-1:0] CMD_STEP           = 8'h53,
   parameter logic [LEN-1:0]      HALT_WORD          = 32'hFFFFFFFF
) (
   input  logic                    clk,
   input  logic                    reset,
   mips_debug_sequencer_if.master  uart,
   input  logic                    halt,
   input  logic [LEN-1:0]          pc,
   output logic [LEN-1:0]          addr_mem_inst,
   output logic [LEN-1:0]          ins_to_mem,
   output logic                    write_enable_ram_inst,
   output logic                    reset_mips,
   output logic                    ctrl_clk_mips,
   output logic                    debug,
   output logic [5:0]              state_out
);

   localparam logic [5:0] IDLE  = 6'b000001;
   localparam logic [5:0] LOAD  = 6'b000010;
   localparam logic [5:0] WRITE = 6'b000100;
   localparam logic [5:0] RUN   = 6'b001000;
   localparam logic [5:0] STEP  = 6'b010000;
   localparam logic [5:0] SEND  = 6'b100000;

   localparam int BYTES = LEN / LEN_DATA;
   localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int IDX_W = (cant_instrucciones > 1) ? $clog2(cant_instrucciones) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(cant_instrucciones - 1);

   logic [5:0]          state;
   logic [CNT_W-1:0]    cnt;        // byte counter for LOAD and SEND
   logic                phase;      // STEP: enable cycle done; SEND: waiting for tx_done
   logic [IDX_W-1:0]    idx;
   logic [LEN-1:0]      word;
   logic [LEN-1:0]      pc_latch;
   logic                tx_start_r;
   logic [LEN_DATA-1:0] tx_data_r;
   logic [LEN-1:0]      word_shifted;

   // Little-endian assembly: each new byte enters at the top and moves down, so after
   // BYTES shifts the first byte sits in the low lane.
   assign word_shifted = {uart.uart_data_in, word[LEN-1:LEN_DATA]};

   assign state_out             = state;
   assign write_enable_ram_inst = (state == WRITE);
   assign addr_mem_inst         = LEN'(idx);
   assign ins_to_mem            = word;
   assign uart.tx_start         = tx_start_r;
   assign uart.uart_data_out    = tx_data_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         phase         <= 1'b0;
         idx           <= '0;
         word          <= '0;
         pc_latch      <= '0;
         tx_start_r    <= 1'b0;
         tx_data_r     <= '0;
         reset_mips    <= 1'b0;
         ctrl_clk_mips <= 1'b0;
         debug         <= 1'b0;
      end else begin
         tx_start_r <= 1'b0;
         reset_mips <= 1'b0;
         case (state)
            IDLE: begin
               if (uart.rx_done) begin
                  if (uart.uart_data_in == CMD_LOAD) begin
                     state <= LOAD;
                     idx   <= '0;
                     cnt   <= '0;
                  end else if (uart.uart_data_in == CMD_RUN) begin
                     state <= RUN;
                     debug <= 1'b0;
                  end else if (uart.uart_data_in == CMD_STEP) begin
                     state         <= STEP;
                     debug         <= 1'b1;
                     ctrl_clk_mips <= 1'b1;
                     phase         <= 1'b0;
                  end
               end
            end
            LOAD: begin
               if (uart.rx_done) begin
                  word <= word_shifted;
                  if (cnt == LAST_BYTE) begin
                     cnt   <= '0;
                     state <= WRITE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            WRITE: begin
               if (word == HALT_WORD || idx == LAST_IDX) begin
                  reset_mips <= 1'b1;
                  idx        <= '0;
                  state      <= IDLE;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= LOAD;
                  // A byte landing in the write cycle already belongs to the next word.
                  if (uart.rx_done) begin
                     word <= word_shifted;
                     cnt  <= CNT_W'(1);
                  end else begin
                     cnt <= '0;
                  end
               end
            end
            RUN: begin
               if (halt) begin
                  ctrl_clk_mips <= 1'b0;
                  pc_latch      <= pc;
                  cnt           <= '0;
                  phase         <= 1'b0;
                  state         <= SEND;
               end else begin
                  ctrl_clk_mips <= 1'b1;
               end
            end
            STEP: begin
               if (!phase) begin
                  ctrl_clk_mips <= 1'b0;
                  phase         <= 1'b1;
               end else begin
                  // PC has advanced by now; the enable cycle ended on the previous edge.
                  pc_latch <= pc;
                  cnt      <= '0;
                  phase    <= 1'b0;
                  state    <= SEND;
               end
            end
            SEND: begin
               if (!phase) begin
                  tx_start_r <= 1'b1;
                  tx_data_r  <= pc_latch[LEN_DATA-1:0];
                  pc_latch   <= pc_latch >> LEN_DATA;
                  phase      <= 1'b1;
               end else if (uart.tx_done) begin
                  phase <= 1'b0;
                  if (cnt == LAST_BYTE) begin
                     cnt   <= '0;
                     debug <= 1'b0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_debug_sequencer.sv
// Directed bench for mips_debug_sequencer: reset, program load (with halt word,
// full depth and overlapping byte), run until halt, single step, noise bytes.
module tb_mips_debug_sequencer;

   localparam logic [5:0] S_IDLE  = 6'b000001;
   localparam logic [5:0] S_LOAD  = 6'b000010;
   localparam logic [5:0] S_WRITE = 6'b000100;
   localparam logic [5:0] S_RUN   = 6'b001000;
   localparam logic [5:0] S_STEP  = 6'b010000;
   localparam logic [5:0] S_SEND  = 6'b100000;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt;
   logic [31:0] pc;
   logic [31:0] addr_mem_inst;
   logic [31:0] ins_to_mem;
   logic        write_enable_ram_inst;
   logic        reset_mips;
   logic        ctrl_clk_mips;
   logic        debug;
   logic [5:0]  state_out;

   int checks = 0;
   int errors = 0;

   mips_debug_sequencer_if u_if ();

   mips_debug_sequencer dut (
      .clk                   (clk),
      .reset                 (reset),
      .uart                  (u_if),
      .halt                  (halt),
      .pc                    (pc),
      .addr_mem_inst         (addr_mem_inst),
      .ins_to_mem            (ins_to_mem),
      .write_enable_ram_inst (write_enable_ram_inst),
      .reset_mips            (reset_mips),
      .ctrl_clk_mips         (ctrl_clk_mips),
      .debug                 (debug),
      .state_out             (state_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, " state"}, 32'(state_out), 32'(S_IDLE));
      check({tag, " ctl outs"}, 32'({u_if.tx_start, write_enable_ram_inst, reset_mips,
                                    ctrl_clk_mips, debug}), 32'd0);
      check({tag, " tx data"}, 32'(u_if.uart_data_out), 32'd0);
      check({tag, " addr"}, addr_mem_inst, 32'd0);
      check({tag, " ins"}, ins_to_mem, 32'd0);
   endtask

   // Drive one rx_done pulse; returns at the negedge after the DUT sampled it.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      u_if.rx_done      = 1'b1;
      u_if.uart_data_in = b;
      @(negedge clk);
      u_if.rx_done      = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      send_byte(w[23:16]);
      send_byte(w[31:24]);
   endtask

   // Acts as the UART transmitter for one byte; optionally injects a run command
   // while the byte is in flight.
   task automatic serve_tx(input string tag, input logic [7:0] exp, input bit inject);
      int w;
      int extra;
      w = 0;
      while (u_if.tx_start !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check({tag, " start"}, 32'(u_if.tx_start), 32'd1);
      check({tag, " data"}, 32'(u_if.uart_data_out), 32'(exp));
      extra = 0;
      for (int i = 0; i < 3; i++) begin
         if (inject && i == 0) begin
            u_if.rx_done      = 1'b1;
            u_if.uart_data_in = 8'h52;
         end else begin
            u_if.rx_done = 1'b0;
         end
         @(negedge clk);
         if (u_if.tx_start) extra++;
      end
      u_if.rx_done = 1'b0;
      check({tag, " no restart"}, 32'(extra), 32'd0);
      if (inject) check({tag, " noise ignored"}, 32'(state_out), 32'(S_SEND));
      check({tag, " data held"}, 32'(u_if.uart_data_out), 32'(exp));
      u_if.tx_done = 1'b1;
      @(negedge clk);
      u_if.tx_done = 1'b0;
   endtask

   initial begin
      int high;
      logic [31:0] v;
      reset             = 1'b1;
      halt              = 1'b0;
      pc                = 32'd0;
      u_if.rx_done      = 1'b0;
      u_if.uart_data_in = 8'h00;
      u_if.tx_done      = 1'b0;

      repeat (2) @(negedge clk);
      check_reset("por");
      reset = 1'b0;

      // Noise in IDLE
      send_byte(8'h41);
      check("noise idle", 32'(state_out), 32'(S_IDLE));

      // Three-word load ending on HALT_WORD, with a byte in the first write cycle
      send_byte(8'h4C);
      check("load entry", 32'(state_out), 32'(S_LOAD));
      send_word(32'h00000013);
      check("w0 state", 32'(state_out), 32'(S_WRITE));
      check("w0 we", 32'(write_enable_ram_inst), 32'd1);
      check("w0 addr", addr_mem_inst, 32'd0);
      check("w0 ins", ins_to_mem, 32'h00000013);
      u_if.rx_done      = 1'b1;
      u_if.uart_data_in = 8'h04;
      @(negedge clk);
      u_if.rx_done = 1'b0;
      check("overlap state", 32'(state_out), 32'(S_LOAD));
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      check("w1 we", 32'(write_enable_ram_inst), 32'd1);
      check("w1 addr", addr_mem_inst, 32'd1);
      check("w1 ins", ins_to_mem, 32'h00000004);
      check("w1 no rst", 32'(reset_mips), 32'd0);
      send_word(32'hFFFFFFFF);
      check("w2 we", 32'(write_enable_ram_inst), 32'd1);
      check("w2 addr", addr_mem_inst, 32'd2);
      check("w2 ins", ins_to_mem, 32'hFFFFFFFF);
      @(negedge clk);
      check("halt word rst", 32'(reset_mips), 32'd1);
      check("halt word idle", 32'(state_out), 32'(S_IDLE));
      check("halt word we off", 32'(write_enable_ram_inst), 32'd0);
      @(negedge clk);
      check("rst pulse width", 32'(reset_mips), 32'd0);

      // Full-depth load: 64 non-halt words
      send_byte(8'h4C);
      for (int i = 0; i < 64; i++) begin
         v = 32'h00000100 + 32'(i);
         send_word(v);
         check("full we", 32'(write_enable_ram_inst), 32'd1);
         check("full addr", addr_mem_inst, 32'(i));
         check("full ins", ins_to_mem, v);
      end
      @(negedge clk);
      check("full rst", 32'(reset_mips), 32'd1);
      check("full idle", 32'(state_out), 32'(S_IDLE));
      high = 0;
      for (int i = 0; i < 4; i++) begin
         send_byte(8'h11 * 8'(i + 1));
         if (write_enable_ram_inst) high++;
      end
      check("65th word not written", 32'(high), 32'd0);
      check("65th word idle", 32'(state_out), 32'(S_IDLE));

      // Run until halt
      halt = 1'b0;
      pc   = 32'd0;
      send_byte(8'h52);
      check("run state", 32'(state_out), 32'(S_RUN));
      check("run debug", 32'(debug), 32'd0);
      high = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ctrl_clk_mips) high++;
      end
      halt = 1'b1;
      pc   = 32'h00000020;
      @(negedge clk);
      if (ctrl_clk_mips) high++;
      check("run enable cycles", 32'(high), 32'd10);
      check("run to send", 32'(state_out), 32'(S_SEND));
      serve_tx("run b0", 8'h20, 1'b0);
      serve_tx("run b1", 8'h00, 1'b0);
      serve_tx("run b2", 8'h00, 1'b0);
      serve_tx("run b3", 8'h00, 1'b0);
      check("run done idle", 32'(state_out), 32'(S_IDLE));
      check("run done enable", 32'(ctrl_clk_mips), 32'd0);
      halt = 1'b0;

      // Single step, with a run command arriving mid-send
      pc = 32'd0;
      send_byte(8'h53);
      check("step state", 32'(state_out), 32'(S_STEP));
      check("step enable", 32'(ctrl_clk_mips), 32'd1);
      check("step debug", 32'(debug), 32'd1);
      pc = 32'h00000004;
      @(negedge clk);
      check("step enable drop", 32'(ctrl_clk_mips), 32'd0);
      @(negedge clk);
      check("step to send", 32'(state_out), 32'(S_SEND));
      check("step enable off", 32'(ctrl_clk_mips), 32'd0);
      serve_tx("step b0", 8'h04, 1'b0);
      check("step debug held", 32'(debug), 32'd1);
      serve_tx("step b1", 8'h00, 1'b1);
      serve_tx("step b2", 8'h00, 1'b0);
      check("step debug late", 32'(debug), 32'd1);
      serve_tx("step b3", 8'h00, 1'b0);
      check("step done idle", 32'(state_out), 32'(S_IDLE));
      check("step debug clr", 32'(debug), 32'd0);

      // Reset in the middle of a run
      halt = 1'b0;
      send_byte(8'h52);
      repeat (3) @(negedge clk);
      check("mid-run enable", 32'(ctrl_clk_mips), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_reset("mid-run reset");
      reset = 1'b0;
      @(negedge clk);
      check("post reset idle", 32'(state_out), 32'(S_IDLE));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_debug_sequencer.md
Name: mips_debug_sequencer

Overview:
Host-side debug controller for the pipelined MIPS core. It decodes single-byte UART commands, loads a program word-by-word into instruction memory, and gates the MIPS clock enable for free-run or single-step execution. After each run or step it reports the PC back over the UART. It sits between the UART (rx/tx handshake) and the MIPS top (instruction-memory write port, clock gate, reset, halt, pc).

Parameters:
LEN, 32, datapath / instruction / PC width
LEN_DATA, 8, UART byte width
cant_instrucciones, 64, instruction memory depth in words
CMD_LOAD, 8'h4C, command byte: load program
CMD_RUN, 8'h52, command byte: run until halt
CMD_STEP, 8'h53, command byte: single step
HALT_WORD, 32'hFFFFFFFF, instruction encoding that terminates a load

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
rx_done  in  1  UART byte-received pulse, 1 cycle
uart_data_in  in  LEN_DATA  received byte, valid with rx_done
tx_done  in  1  UART byte-sent pulse, 1 cycle
halt  in  1  MIPS halt flag, level
pc  in  LEN  MIPS current PC
tx_start  out  1  UART transmit request pulse
uart_data_out  out  LEN_DATA  byte to transmit, held stable until tx_done
addr_mem_inst  out  LEN  instruction memory word index
ins_to_mem  out  LEN  instruction word to write
write_enable_ram_inst  out  1  instruction memory write strobe
reset_mips  out  1  MIPS core reset pulse
ctrl_clk_mips  out  1  MIPS clock enable
debug  out  1  1 = step mode, 0 = run mode
state_out  out  6  one-hot state, driven to LEDs

Behaviour:
- Reset: state IDLE; all outputs 0 except state_out=6'b000001; byte counter, word index, assembly and PC-latch registers cleared. Reset takes priority over every event. A reset during RUN drops ctrl_clk_mips on the same edge.
- States (one-hot on state_out): IDLE=000001, LOAD=000010, WRITE=000100, RUN=001000, STEP=010000, SEND=100000.
- IDLE: rx_done with CMD_LOAD -> LOAD (word index=0, byte count=0). CMD_RUN -> RUN, debug=0. CMD_STEP -> STEP, debug=1. Any other byte is ignored.
- LOAD: on each rx_done, shift the byte into the word, little-endian (1st byte -> [7:0], 4th byte -> [31:24]). After the 4th byte -> WRITE.
- WRITE (exactly 1 cycle): write_enable_ram_inst=1, addr_mem_inst=word index, ins_to_mem=assembled word.
  - If word==HALT_WORD or index==cant_instrucciones-1: reset_mips=1 for the next single cycle, word index resets to 0, go to IDLE.
  - Otherwise: index+1, go to LOAD.
  - An rx_done arriving in the WRITE cycle is captured as byte 0 of the next word.
- RUN: ctrl_clk_mips=1 while halt=0. On the first cycle halt is sampled 1, ctrl_clk_mips=0 on the next edge, pc is latched, and the block goes to SEND. If halt is already 1 on entry, ctrl_clk_mips is never asserted.
- STEP: ctrl_clk_mips=1 for exactly one cycle, then 0. pc is latched on the following cycle, then the block goes to SEND.
- SEND: transmit the latched PC as 4 bytes, LSB first.
  - Per byte: tx_start pulses 1 cycle with uart_data_out valid, then the block waits for tx_done.
  - After the 4th tx_done -> IDLE. debug is held until IDLE is re-entered, then cleared.
- rx_done in RUN, STEP or SEND is ignored; no command queueing.
- tx_start is never reasserted before tx_done of the previous byte. write_enable_ram_inst and reset_mips are never high outside the cycles defined above.

Test Plan:
- Reset mid-RUN (ctrl_clk_mips=1) -> next edge: ctrl_clk_mips=0, state_out=000001, all outputs 0.
- Load: send 4C,13,00,00,00 then 04,00,00,00 then FF,FF,FF,FF -> write strobes at addr 0 (00000013), addr 1 (00000004), addr 2 (FFFFFFFF); one-cycle reset_mips after the 3rd write; back in IDLE.
- Full-depth load: 64 words, none equal to HALT_WORD -> last write at addr 63, then reset_mips pulse; a 65th word is not written without a new 4C.
- Run: send 52, halt rises 10 cycles later with pc=0x00000020 -> ctrl_clk_mips high for exactly 10 cycles; tx bytes 20,00,00,00, one tx_start per tx_done.
- Step: send 53 with pc=0x00000004 after the step -> ctrl_clk_mips high for 1 cycle, debug=1 through SEND; tx bytes 04,00,00,00.
- Noise/overlap: byte 0x41 in IDLE and 0x52 during SEND -> both ignored, state unchanged; byte arriving in the WRITE cycle is stored as byte 0 of the next word.
